reduce_combine: RTL and testbench

REDUCE_COMBINE -- requirements
Module: reduce_combine

---
 rtl/reduce_combine.sv | 194 +++++++++++++++++++
 tb/tb_reduce_combine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_combine.sv
// Reduction/combine stage: merges children-tagged flits sharing a key
// into one result flit per reduction, with leaf and bypass forwarding.
module reduce_combine #(
  parameter int FlitWidth          = 82,
  parameter int ChildrenWidth      = 3,
  parameter int ReductionTableSize = 6,
  parameter int PayloadWidth       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth+ChildrenWidth-1:0] in_flit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [FlitWidth-1:0]               out_flit,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [2:0]                         occupancy
);

  localparam int N    = ReductionTableSize;
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int HdrW = FlitWidth - PayloadWidth;
  localparam int VBit = 81;

  localparam logic [3:0] OpSum    = 4'b0000;
  localparam logic [3:0] OpMax    = 4'b0001;
  localparam logic [3:0] OpMin    = 4'b0010;
  localparam logic [3:0] OpAnd    = 4'b0011;
  localparam logic [3:0] OpOr     = 4'b0100;
  localparam logic [3:0] OpXor    = 4'b0101;
  localparam logic [3:0] OpBypass = 4'b1111;

  typedef logic [PayloadWidth-1:0] pay_t;
  typedef logic [ChildrenWidth-1:0] ch_t;

  logic             r_busy [N];
  logic [7:0]       r_ctx  [N];
  logic [7:0]       r_tag  [N];
  logic [3:0]       r_op   [N];
  ch_t              r_rem  [N];
  pay_t             r_acc  [N];
  logic [HdrW-1:0]  r_hdr  [N];

  logic                 r_out_valid;
  logic [FlitWidth-1:0] r_out_flit;
  logic [2:0]           r_occ;

  logic            w_vbit;
  logic [7:0]      w_ctx;
  logic [7:0]      w_tag;
  logic [3:0]      w_op;
  pay_t            w_pay;
  logic [HdrW-1:0] w_hdr;
  ch_t             w_ch;

  logic            w_hit;
  logic [IdxW-1:0] w_hit_idx;
  logic            w_free_any;
  logic [IdxW-1:0] w_free_idx;

  logic w_bypass;
  logic w_stall;
  logic w_acc_in;
  logic w_do_bypass;
  logic w_do_hit;
  logic w_do_leaf;
  logic w_do_alloc;
  logic w_done;
  logic w_load;

  ch_t                  w_hit_rem;
  pay_t                 w_new_acc;
  logic [FlitWidth-1:0] w_out_next;

  function automatic pay_t f_combine(
    input logic [3:0] op,
    input pay_t       a,
    input pay_t       b
  );
    pay_t r;
    case (op)
      OpMax:   r = (a > b) ? a : b;
      OpMin:   r = (a < b) ? a : b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSum:   r = a + b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign w_vbit = in_flit[VBit];
  assign w_ctx  = in_flit[53:46];
  assign w_tag  = in_flit[45:38];
  assign w_op   = in_flit[35:32];
  assign w_pay  = in_flit[PayloadWidth-1:0];
  assign w_hdr  = in_flit[FlitWidth-1:PayloadWidth];
  assign w_ch   = in_flit[FlitWidth +: ChildrenWidth];

  // Descending scan so the last match written is the lowest index.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_busy[i] && r_ctx[i] == w_ctx && r_tag[i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_idx = IdxW'(i);
      end
      if (!r_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IdxW'(i);
      end
    end
  end

  assign w_bypass = (w_op == OpBypass);
  assign w_stall  = r_out_valid & ~out_ready;

  assign in_ready = ~w_stall &
                    (w_hit | w_free_any | ~w_vbit | w_bypass);

  assign w_acc_in    = in_valid & in_ready & w_vbit;
  assign w_do_bypass = w_acc_in & w_bypass;
  assign w_do_hit    = w_acc_in & ~w_bypass & w_hit;
  assign w_do_leaf   = w_acc_in & ~w_bypass & ~w_hit &
                       (w_ch <= ch_t'(1));
  assign w_do_alloc  = w_acc_in & ~w_bypass & ~w_hit &
                       (w_ch > ch_t'(1));

  assign w_hit_rem = r_rem[w_hit_idx];
  assign w_new_acc = f_combine(r_op[w_hit_idx],
                               r_acc[w_hit_idx], w_pay);
  assign w_done    = w_do_hit & (w_hit_rem == ch_t'(1));
  assign w_load    = w_do_bypass | w_do_leaf | w_done;

  always_comb begin
    w_out_next = in_flit[FlitWidth-1:0];
    if (w_done) begin
      w_out_next       = {r_hdr[w_hit_idx], w_new_acc};
      w_out_next[VBit] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_busy[i] <= 1'b0;
        r_ctx[i]  <= '0;
        r_tag[i]  <= '0;
        r_op[i]   <= '0;
        r_rem[i]  <= '0;
        r_acc[i]  <= '0;
        r_hdr[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_occ       <= '0;
    end else begin
      if (w_do_alloc) begin
        r_busy[w_free_idx] <= 1'b1;
        r_ctx[w_free_idx]  <= w_ctx;
        r_tag[w_free_idx]  <= w_tag;
        r_op[w_free_idx]   <= w_op;
        r_rem[w_free_idx]  <= w_ch - ch_t'(1);
        r_acc[w_free_idx]  <= w_pay;
        r_hdr[w_free_idx]  <= w_hdr;
        r_occ              <= r_occ + 3'd1;
      end
      if (w_do_hit) begin
        r_acc[w_hit_idx] <= w_new_acc;
        r_rem[w_hit_idx] <= w_hit_rem - ch_t'(1);
        if (w_done) begin
          r_busy[w_hit_idx] <= 1'b0;
          r_occ             <= r_occ - 3'd1;
        end
      end
      // New loads only happen when not stalled, so the flit holds otherwise.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_flit  <= w_out_next;
      end else if (!w_stall) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_reduce_combine.sv
// Bench for reduce_combine: directed scenarios plus random traffic
// checked each cycle against a key-indexed reference model.
module tb_reduce_combine;

  localparam int FW = 82;
  localparam int CW = 3;
  localparam int IW = FW + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    occupancy;

  always #5 clk = ~clk;

  reduce_combine #(
    .FlitWidth(FW),
    .ChildrenWidth(CW),
    .ReductionTableSize(6),
    .PayloadWidth(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_flit(in_flit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_flit(out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned m_rem [bit [15:0]];
  bit [31:0]   m_acc [bit [15:0]];
  bit [3:0]    m_op  [bit [15:0]];
  bit [49:0]   m_hdr [bit [15:0]];
  bit          m_ov;
  bit [81:0]   m_of;
  bit          g_acc;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int ch, input bit v,
    input int ctx, input int tag, input int op, input bit [31:0] pay);
    logic [IW-1:0] f;
    f        = '0;
    f[84:82] = 3'(ch);
    f[81]    = v;
    f[80:54] = 27'($urandom);
    f[53:46] = 8'(ctx);
    f[45:38] = 8'(tag);
    f[37:36] = 2'($urandom);
    f[35:32] = 4'(op);
    f[31:0]  = pay;
    return f;
  endfunction

  function automatic bit [31:0] comb(input bit [3:0] op,
                                     input bit [31:0] a, input bit [31:0] b);
    case (op)
      4'd1:    return (a > b) ? a : b;
      4'd2:    return (a < b) ? a : b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic bit m_ready(input logic [IW-1:0] f, input bit ordy);
    bit [15:0] k;
    k = {f[53:46], f[45:38]};
    if (m_ov && !ordy) return 1'b0;
    return !f[81] || f[35:32] == 4'hF || m_rem.exists(k) || m_rem.num() < 6;
  endfunction

  task automatic model_accept(input logic [IW-1:0] f);
    bit [15:0] k;
    k = {f[53:46], f[45:38]};
    if (f[35:32] == 4'hF) begin
      m_ov = 1'b1;
      m_of = f[81:0];
    end else if (m_rem.exists(k)) begin
      m_acc[k] = comb(m_op[k], m_acc[k], f[31:0]);
      m_rem[k] = m_rem[k] - 1;
      if (m_rem[k] == 0) begin
        m_ov     = 1'b1;
        m_of     = {m_hdr[k], m_acc[k]};
        m_of[81] = 1'b1;
        m_rem.delete(k);
        m_acc.delete(k);
        m_op.delete(k);
        m_hdr.delete(k);
      end
    end else if (f[84:82] <= 3'd1) begin
      m_ov = 1'b1;
      m_of = f[81:0];
    end else begin
      m_rem[k] = int'(f[84:82]) - 1;
      m_acc[k] = f[31:0];
      m_op[k]  = f[35:32];
      m_hdr[k] = f[81:32];
    end
  endtask

  // One clock: drive after negedge, check ready, step the model, check outputs.
  task automatic cycle(input logic [IW-1:0] f, input bit v, input bit ordy);
    bit er;
    bit ohs;
    in_flit   = f;
    in_valid  = v;
    out_ready = ordy;
    #1;
    er = m_ready(f, ordy);
    chk("in_ready", 128'(in_ready), 128'(er));
    g_acc = v && er;
    ohs   = m_ov && ordy;
    @(posedge clk);
    if (ohs) m_ov = 1'b0;
    if (g_acc && f[81]) model_accept(f);
    @(negedge clk);
    chk("occupancy", 128'(occupancy), 128'(m_rem.num()));
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    if (m_ov) chk("out_flit", 128'(out_flit), 128'(m_of));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_flit   = mk(3, 1, 9, 9, 0, 1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_ovalid", 128'(out_valid), 128'(0));
    chk("rst_oflit", 128'(out_flit), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    m_rem.delete();
    m_acc.delete();
    m_op.delete();
    m_hdr.delete();
    m_ov     = 1'b0;
    m_of     = '0;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  logic [IW-1:0] f1, f2, f3, fa, fb, fn, idle;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_flit   = '0;
    idle      = '0;
    @(negedge clk);
    do_reset();

    f1 = mk(3, 1, 0, 5, 0, 10);
    cycle(f1, 1, 1);
    chk("sum3_occ_a", 128'(occupancy), 128'(1));
    cycle(mk(3, 1, 0, 5, 0, 20), 1, 1);
    chk("sum3_occ_b", 128'(occupancy), 128'(1));
    cycle(mk(3, 1, 0, 5, 0, 30), 1, 1);
    chk("sum3_occ_c", 128'(occupancy), 128'(0));
    chk("sum3_valid", 128'(out_valid), 128'(1));
    chk("sum3_pay", 128'(out_flit[31:0]), 128'(60));
    chk("sum3_hdr", 128'(out_flit[81:32]), 128'(f1[81:32]));
    cycle(idle, 0, 1);
    chk("sum3_clear", 128'(out_valid), 128'(0));

    cycle(mk(2, 1, 1, 1, 1, 7), 1, 1);
    cycle(mk(2, 1, 1, 2, 5, 32'hF0), 1, 1);
    cycle(mk(2, 1, 1, 1, 1, 3), 1, 1);
    chk("mix_max", 128'(out_flit[31:0]), 128'(7));
    cycle(mk(2, 1, 1, 2, 5, 32'h0F), 1, 1);
    chk("mix_xor", 128'(out_flit[31:0]), 128'(32'hFF));
    cycle(idle, 0, 1);

    for (int i = 0; i < 6; i++) cycle(mk(2, 1, 2, i, 0, i + 1), 1, 1);
    chk("full_occ", 128'(occupancy), 128'(6));
    fn = mk(2, 1, 3, 0, 0, 100);
    cycle(fn, 1, 1);
    chk("full_stall", 128'(in_ready), 128'(0));
    cycle(mk(2, 1, 2, 0, 0, 50), 1, 1);
    chk("full_hit_pay", 128'(out_flit[31:0]), 128'(51));
    chk("full_hit_occ", 128'(occupancy), 128'(5));
    cycle(fn, 1, 1);
    chk("full_7th_occ", 128'(occupancy), 128'(6));
    do_reset();

    cycle(mk(2, 1, 4, 1, 0, 5), 1, 1);
    cycle(mk(2, 1, 4, 2, 0, 6), 1, 1);
    cycle(mk(2, 1, 4, 1, 0, 1), 1, 1);
    fb = mk(2, 1, 4, 2, 0, 2);
    for (int k = 0; k < 4; k++) begin
      cycle((k == 1) ? mk(0, 1, 4, 7, 15, 77) : fb, 1, 0);
      chk("bp_hold", 128'(out_flit[31:0]), 128'(6));
    end
    cycle(fb, 1, 1);
    chk("bp_second", 128'(out_flit[31:0]), 128'(8));
    cycle(idle, 0, 1);

    fa = mk(0, 1, 5, 1, 0, 32'hFFFF_FFFF);
    cycle(fa, 1, 1);
    chk("leaf_fwd", 128'(out_flit), 128'(fa[81:0]));
    fb = mk(3, 1, 5, 2, 15, 123);
    cycle(fb, 1, 1);
    chk("bypass_fwd", 128'(out_flit), 128'(fb[81:0]));
    cycle(mk(2, 0, 5, 3, 0, 9), 1, 1);
    chk("inv_drop_v", 128'(out_valid), 128'(0));
    chk("inv_drop_occ", 128'(occupancy), 128'(0));
    cycle(mk(2, 1, 5, 4, 0, 32'hFFFF_FFFF), 1, 1);
    cycle(mk(2, 1, 5, 4, 0, 2), 1, 1);
    chk("wrap_sum", 128'(out_flit[31:0]), 128'(1));
    cycle(idle, 0, 1);

    cycle(mk(3, 1, 6, 6, 0, 10), 1, 1);
    chk("rmid_occ", 128'(occupancy), 128'(1));
    do_reset();
    cycle(mk(3, 1, 6, 6, 0, 20), 1, 1);
    chk("rmid_fresh", 128'(occupancy), 128'(1));
    cycle(mk(3, 1, 6, 6, 0, 30), 1, 1);
    chk("rmid_pending", 128'(out_valid), 128'(0));
    cycle(mk(3, 1, 6, 6, 0, 40), 1, 1);
    chk("rmid_sum", 128'(out_flit[31:0]), 128'(90));
    cycle(idle, 0, 1);

    for (int n = 0; n < 500; n++) begin
      f1 = mk($urandom_range(0, 4), $urandom_range(0, 9) != 0,
              $urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 7),
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                          : $urandom);
      cycle(f1, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7);
    end
    for (int n = 0; n < 4; n++) cycle(idle, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
